// File: rtl/parking_pkg.sv
// Shared types and default constants for the parking gate scheduler.
// The gate FSM states, the lane identifiers and the timer width helper live here.
package parking_pkg;

   typedef enum logic [1:0] {
      IDLE,
      OPEN_ENTRY,
      OPEN_EXIT,
      HOLD
   } gate_state_t;

   typedef enum logic {
      LANE_ENTRY,
      LANE_EXIT
   } lane_t;

   localparam int DEF_CAPACITY = 16;
   localparam int DEF_PASS_TMO = 32;
   localparam int DEF_HOLD_CYC = 8;

   // The timer holds count-1 values, so it needs enough bits for max(pass, hold) - 1.
   function automatic int timer_width(input int pass_tmo, input int hold_cyc);
      int m;
      m = (pass_tmo > hold_cyc) ? pass_tmo : hold_cyc;
      return (m <= 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/parking_gate_timer.sv
// Loadable down-counter shared by the open-gate timeout and the hold-closed period.
// expired is high while the count sits at zero; load takes priority over ticking.
module parking_gate_timer #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         tick_en,
   output logic         expired
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (tick_en && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == '0);

endmodule

// File: rtl/parking_gate_scheduler.sv
// Arbitrates the single barrier gate between entrance and exit lanes, sequencing
// open / car pass / hold-closed and tracking lot occupancy against capacity.
module parking_gate_scheduler
   import parking_pkg::*;
#(
   parameter int CAPACITY = DEF_CAPACITY,
   parameter int PASS_TMO = DEF_PASS_TMO,
   parameter int HOLD_CYC = DEF_HOLD_CYC,
   parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             entry_req,
   input  logic             exit_req,
   input  logic             car_passed,
   output logic             entry_grant,
   output logic             exit_grant,
   output logic             gate_open,
   output logic [CNT_W-1:0] occupancy,
   output logic             full,
   output logic             empty,
   output logic             tmo_fault
);

   localparam int TMR_W = timer_width(PASS_TMO, HOLD_CYC);
   localparam logic [TMR_W-1:0] PASS_LOAD = TMR_W'(PASS_TMO - 1);
   localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] CAP_VAL   = CNT_W'(CAPACITY);

   gate_state_t      state_q, state_d;
   lane_t            last_served_q, last_served_d;
   logic [CNT_W-1:0] occupancy_q, occupancy_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             entry_grant_q, entry_grant_d;
   logic             exit_grant_q, exit_grant_d;
   logic             gate_open_q, gate_open_d;
   logic             tmo_fault_q, tmo_fault_d;

   logic             entry_ok, exit_ok;
   logic             tmo_event;
   logic             timer_load;
   logic [TMR_W-1:0] timer_load_val;
   logic             timer_tick;
   logic             timer_expired;

   assign entry_ok = entry_req & ~full_q;
   assign exit_ok  = exit_req & ~empty_q;

   parking_gate_timer #(
      .W (TMR_W)
   ) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (timer_load),
      .load_val (timer_load_val),
      .tick_en  (timer_tick),
      .expired  (timer_expired)
   );

   // State register: FSM, arbitration history, occupancy and every registered output.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         last_served_q <= LANE_EXIT;
         occupancy_q   <= '0;
         full_q        <= 1'b0;
         empty_q       <= 1'b1;
         entry_grant_q <= 1'b0;
         exit_grant_q  <= 1'b0;
         gate_open_q   <= 1'b0;
         tmo_fault_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_served_q <= last_served_d;
         occupancy_q   <= occupancy_d;
         full_q        <= full_d;
         empty_q       <= empty_d;
         entry_grant_q <= entry_grant_d;
         exit_grant_q  <= exit_grant_d;
         gate_open_q   <= gate_open_d;
         tmo_fault_q   <= tmo_fault_d;
      end
   end

   // Next state: round-robin pick in IDLE, car_passed beats a simultaneous timeout.
   always_comb begin
      state_d        = state_q;
      last_served_d  = last_served_q;
      timer_load     = 1'b0;
      timer_load_val = PASS_LOAD;
      timer_tick     = 1'b0;
      tmo_event      = 1'b0;
      case (state_q)
         IDLE: begin
            if (entry_ok && (!exit_ok || (last_served_q == LANE_EXIT))) begin
               state_d       = OPEN_ENTRY;
               last_served_d = LANE_ENTRY;
               timer_load    = 1'b1;
            end else if (exit_ok) begin
               state_d       = OPEN_EXIT;
               last_served_d = LANE_EXIT;
               timer_load    = 1'b1;
            end
         end
         OPEN_ENTRY, OPEN_EXIT: begin
            timer_tick = 1'b1;
            if (car_passed) begin
               state_d        = HOLD;
               timer_load     = 1'b1;
               timer_load_val = HOLD_LOAD;
            end else if (timer_expired) begin
               state_d        = HOLD;
               timer_load     = 1'b1;
               timer_load_val = HOLD_LOAD;
               tmo_event      = 1'b1;
            end
         end
         HOLD: begin
            timer_tick = 1'b1;
            if (timer_expired) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs: decoded from the upcoming state so they register alongside it.
   always_comb begin
      occupancy_d = occupancy_q;
      if ((state_q == OPEN_ENTRY) && car_passed && (occupancy_q != CAP_VAL)) begin
         occupancy_d = occupancy_q + CNT_W'(1);
      end else if ((state_q == OPEN_EXIT) && car_passed && (occupancy_q != '0)) begin
         occupancy_d = occupancy_q - CNT_W'(1);
      end
      full_d        = (occupancy_d == CAP_VAL);
      empty_d       = (occupancy_d == '0);
      entry_grant_d = (state_q == IDLE) && (state_d == OPEN_ENTRY);
      exit_grant_d  = (state_q == IDLE) && (state_d == OPEN_EXIT);
      gate_open_d   = (state_d == OPEN_ENTRY) || (state_d == OPEN_EXIT);
      tmo_fault_d   = tmo_event;
   end

   assign entry_grant = entry_grant_q;
   assign exit_grant  = exit_grant_q;
   assign gate_open   = gate_open_q;
   assign occupancy   = occupancy_q;
   assign full        = full_q;
   assign empty       = empty_q;
   assign tmo_fault   = tmo_fault_q;

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Directed bench for parking_gate_scheduler: a lane scoreboard plus an occupancy
// model predict each grant and count; immediate assertions compare at each step.
module tb_parking_gate_scheduler;

   localparam int CAP = 16;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       entry_req;
   logic       exit_req;
   logic       car_passed;
   logic       entry_grant;
   logic       exit_grant;
   logic       gate_open;
   logic [4:0] occupancy;
   logic       full;
   logic       empty;
   logic       tmo_fault;

   int checks = 0;
   int errors = 0;
   int exp_occ = 0;
   int exp_last = 1;
   int exp_lane_q[$];
   int seq_occ[3] = '{6, 5, 6};
   int seq_lane[3] = '{0, 1, 0};

   always #5 clk = ~clk;

   parking_gate_scheduler dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .entry_req   (entry_req),
      .exit_req    (exit_req),
      .car_passed  (car_passed),
      .entry_grant (entry_grant),
      .exit_grant  (exit_grant),
      .gate_open   (gate_open),
      .occupancy   (occupancy),
      .full        (full),
      .empty       (empty),
      .tmo_fault   (tmo_fault)
   );

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Reference arbitration: 0 = entry, 1 = exit, -1 = nothing eligible.
   function automatic int model_lane();
      bit e_ok;
      bit x_ok;
      e_ok = entry_req && (exp_occ != CAP);
      x_ok = exit_req && (exp_occ != 0);
      if (e_ok && x_ok) return (exp_last == 1) ? 0 : 1;
      if (e_ok) return 0;
      if (x_ok) return 1;
      return -1;
   endfunction

   task automatic wait_grant(input string tag, output int waited);
      bit seen;
      int exp_lane;
      logic [31:0] exp_vec;
      seen = 1'b0;
      waited = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         waited++;
         if (entry_grant || exit_grant) seen = 1'b1;
      end
      check_output({tag, "_grant_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         exp_lane = (exp_lane_q.size() > 0) ? exp_lane_q.pop_front() : -1;
         exp_vec = (exp_lane == 0) ? 32'd2 : ((exp_lane == 1) ? 32'd1 : 32'd3);
         check_output({tag, "_lane"}, {30'd0, entry_grant, exit_grant}, exp_vec);
         check_output({tag, "_gate_open"}, 32'(gate_open), 32'd1);
         exp_last = exp_lane;
      end
   endtask

   task automatic expect_quiet(input string tag, input int n);
      repeat (n) begin
         @(negedge clk);
         check_output(tag, {29'd0, gate_open, entry_grant, exit_grant}, 32'd0);
      end
   endtask

   // One full service with the requests currently driven: grant, car pass, hold.
   task automatic apply_stimulus(input string tag, input int pass_delay, output int waited);
      int lane;
      lane = model_lane();
      exp_lane_q.push_back(lane);
      wait_grant(tag, waited);
      repeat (pass_delay) begin
         @(negedge clk);
         check_output({tag, "_still_open"}, 32'(gate_open), 32'd1);
      end
      car_passed = 1'b1;
      @(negedge clk);
      car_passed = 1'b0;
      if (lane == 0 && exp_occ < CAP) exp_occ++;
      else if (lane == 1 && exp_occ > 0) exp_occ--;
      check_output({tag, "_occ"}, 32'(occupancy), exp_occ);
      check_output({tag, "_flags"}, {29'd0, gate_open, full, empty},
                   {29'd0, 1'b0, exp_occ == CAP, exp_occ == 0});
      expect_quiet({tag, "_hold"}, 8);
   endtask

   initial begin
      int waited;
      reset_n = 1'b0;
      entry_req = 1'b0;
      exit_req = 1'b0;
      car_passed = 1'b0;
      repeat (3) @(negedge clk);
      check_output("reset_outputs", {26'd0, gate_open, entry_grant, exit_grant, tmo_fault, full, empty}, 32'd1);
      check_output("reset_occ", 32'(occupancy), 32'd0);
      reset_n = 1'b1;

      $display("[TB] exit request while empty");
      exit_req = 1'b1;
      expect_quiet("t4_no_exit_grant", 20);
      check_output("t4_empty", 32'(empty), 32'd1);
      check_output("t4_occ", 32'(occupancy), 32'd0);
      exit_req = 1'b0;

      $display("[TB] single entry with hold period");
      @(negedge clk);
      entry_req = 1'b1;
      exp_lane_q.push_back(model_lane());
      wait_grant("t1", waited);
      check_output("t1_latency", waited, 32'd1);
      entry_req = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check_output("t1_open_after_drop", 32'(gate_open), 32'd1);
      end
      car_passed = 1'b1;
      @(negedge clk);
      car_passed = 1'b0;
      exp_occ = 1;
      check_output("t1_occ", 32'(occupancy), 32'd1);
      check_output("t1_closed", {30'd0, gate_open, empty}, 32'd0);
      entry_req = 1'b1;
      expect_quiet("t1_hold", 8);
      apply_stimulus("t1b", 0, waited);
      check_output("t1_idle_after_hold", waited, 32'd1);

      $display("[TB] round-robin with both lanes");
      repeat (4) apply_stimulus("t2_fill", 1, waited);
      entry_req = 1'b0;
      exit_req = 1'b1;
      apply_stimulus("t2_exit", 0, waited);
      check_output("t2_occ5", 32'(occupancy), 32'd5);
      entry_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         apply_stimulus("t2_rr", 0, waited);
         check_output("t2_occ_seq", 32'(occupancy), seq_occ[i]);
         check_output("t2_lane_seq", exp_last, seq_lane[i]);
      end

      $display("[TB] full lot blocks entry");
      exit_req = 1'b0;
      repeat (10) apply_stimulus("t3_fill", 0, waited);
      check_output("t3_full", 32'(full), 32'd1);
      check_output("t3_occ16", 32'(occupancy), 32'd16);
      expect_quiet("t3_blocked", 20);
      exit_req = 1'b1;
      apply_stimulus("t3_exit", 0, waited);
      check_output("t3_occ15", 32'(occupancy), 32'd15);
      exit_req = 1'b0;
      apply_stimulus("t3_reentry", 0, waited);
      check_output("t3_refull", 32'(full), 32'd1);

      $display("[TB] pass timeout");
      entry_req = 1'b0;
      exit_req = 1'b1;
      exp_lane_q.push_back(model_lane());
      wait_grant("t5", waited);
      exit_req = 1'b0;
      for (int k = 1; k < 32; k++) begin
         @(negedge clk);
         check_output("t5_waiting", {30'd0, tmo_fault, gate_open}, 32'd1);
      end
      @(negedge clk);
      check_output("t5_tmo", {30'd0, tmo_fault, gate_open}, 32'd2);
      check_output("t5_occ", 32'(occupancy), 32'd16);
      car_passed = 1'b1;
      @(negedge clk);
      car_passed = 1'b0;
      check_output("t5_tmo_pulse", 32'(tmo_fault), 32'd0);
      check_output("t5_pass_in_hold", 32'(occupancy), 32'd16);
      expect_quiet("t5_hold", 7);

      $display("[TB] reset while open");
      exit_req = 1'b1;
      repeat (9) apply_stimulus("t6_drain", 0, waited);
      check_output("t6_occ7", 32'(occupancy), 32'd7);
      exp_lane_q.push_back(model_lane());
      wait_grant("t6", waited);
      exit_req = 1'b0;
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check_output("t6_async_gate", 32'(gate_open), 32'd0);
      check_output("t6_async_occ", 32'(occupancy), 32'd0);
      check_output("t6_async_empty", 32'(empty), 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      exp_occ = 0;
      exp_last = 1;
      exp_lane_q.delete();
      @(negedge clk);
      check_output("t6_closed", 32'(gate_open), 32'd0);
      entry_req = 1'b1;
      apply_stimulus("t6_idle", 0, waited);
      check_output("t6_idle_latency", waited, 32'd1);
      check_output("t6_occ1", 32'(occupancy), 32'd1);
      entry_req = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
